// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if: request inputs and lamp/status outputs of the intersection scheduler
//   master: drives sensor, ped_req, emerg; observes light_highway, light_farm, walk, state_o
//   slave : the scheduler itself
interface intersection_scheduler_if;
    logic       sensor;
    logic       ped_req;
    logic       emerg;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       walk;
    logic [2:0] state_o;
    modport master(output sensor, ped_req, emerg, input light_highway, light_farm, walk, state_o);
    modport slave(input sensor, ped_req, emerg, output light_highway, light_farm, walk, state_o);
endinterface

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: highway/farm-road light sequencer with pedestrian WALK and emergency pre-emption
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of intersection_scheduler_if (sensor, ped_req, emerg in; lamps, walk, state_o out)
module intersection_scheduler #(
    parameter int CLK_PER_TICK = 4,
    parameter int HW_MIN_GREEN = 10,
    parameter int FARM_GREEN   = 6,
    parameter int YELLOW       = 3,
    parameter int ALL_RED      = 1
) (
    input logic clk,
    input logic rst,
    intersection_scheduler_if.slave bus
);
    localparam int M1   = HW_MIN_GREEN > FARM_GREEN ? HW_MIN_GREEN : FARM_GREEN;
    localparam int M2   = YELLOW > ALL_RED ? YELLOW : ALL_RED;
    localparam int TMAX = M1 > M2 ? M1 : M2;
    localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int PW   = CLK_PER_TICK > 1 ? $clog2(CLK_PER_TICK) : 1;
    typedef enum logic [2:0] {HGRN = 3'd0, HYEL = 3'd1, ARED1 = 3'd2, FGRN = 3'd3, FYEL = 3'd4, ARED2 = 3'd5} state_t;
    state_t state, nxt;
    logic [PW-1:0] psc;
    logic [TW-1:0] tcnt;
    logic ped_pend, ped_serv, min_done, tick, exp_hw, exp_fg, exp_y, exp_ar, enter_fgrn;
    logic [2:0] hw_lamp, farm_lamp;
    function automatic logic [5:0] lamps(state_t s);
        return s == HGRN ? 6'b001_100 :
               s == HYEL ? 6'b010_100 :
               s == FGRN ? 6'b100_001 :
               s == FYEL ? 6'b100_010 : 6'b100_100;
    endfunction
    assign tick       = psc == PW'(CLK_PER_TICK - 1);
    assign exp_hw     = tick && tcnt == TW'(HW_MIN_GREEN - 1);
    assign exp_fg     = tick && tcnt == TW'(FARM_GREEN - 1);
    assign exp_y      = tick && tcnt == TW'(YELLOW - 1);
    assign exp_ar     = tick && tcnt == TW'(ALL_RED - 1);
    assign enter_fgrn = nxt == FGRN && state != FGRN;
    always_comb begin
        nxt = state;
        case (state)
            HGRN:    if ((min_done | exp_hw) & (bus.sensor | ped_pend) & ~bus.emerg) nxt = HYEL;
            HYEL:    if (exp_y) nxt = ARED1;
            ARED1:   if (exp_ar) nxt = bus.emerg ? HGRN : FGRN;
            FGRN:    if (bus.emerg | exp_fg) nxt = FYEL;
            FYEL:    if (exp_y) nxt = ARED2;
            ARED2:   if (exp_ar) nxt = HGRN;
            default: nxt = HGRN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HGRN;
            psc       <= '0;
            tcnt      <= '0;
            ped_pend  <= 1'b0;
            ped_serv  <= 1'b0;
            min_done  <= 1'b0;
            hw_lamp   <= 3'b001;
            farm_lamp <= 3'b100;
        end else begin
            state                <= nxt;
            {hw_lamp, farm_lamp} <= lamps(nxt);
            // every state change restarts dwell timing from a fresh tick boundary
            if (nxt != state) begin
                psc      <= '0;
                tcnt     <= '0;
                min_done <= 1'b0;
            end else begin
                psc <= tick ? '0 : psc + 1'b1;
                if (tick && tcnt != '1) tcnt <= tcnt + 1'b1;
                if (state == HGRN && exp_hw) min_done <= 1'b1;
            end
            // a request coincident with farm-green entry is served in this phase
            ped_pend <= enter_fgrn ? 1'b0 : ped_pend | bus.ped_req;
            ped_serv <= enter_fgrn ? ped_pend | bus.ped_req : ped_serv & (nxt == FGRN);
        end
    end
    assign bus.light_highway = hw_lamp;
    assign bus.light_farm    = farm_lamp;
    assign bus.walk          = state == FGRN && ped_serv && !bus.emerg;
    assign bus.state_o       = state;
endmodule
